// File: rtl/cim_pkg.sv
// Shared CIM datapath constants and types used by the psum accumulator and the
// ReLU/quantize stage.
package cim_pkg;

    localparam int unsigned LANES                  = 64;
    localparam int unsigned DEFAULT_PSUM_PRECISION = 14;
    localparam int unsigned DEFAULT_OUT_PRECISION  = 18;
    localparam int unsigned DEFAULT_ACT_BITS       = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } psum_state_e;

    // Plane counter width; kept at least one bit so ACT_BITS == 1 still builds.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/psum_lane_shift_add.sv
// One lane of the bit-serial accumulator: sign-extends a plane partial sum and
// either loads it or folds it into the running value as (acc << 1) + ext(p).
module psum_lane_shift_add #(
    parameter int unsigned PSUM_W = 14,
    parameter int unsigned OUT_W  = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              accum,
    input  logic [PSUM_W-1:0] psum_in,
    output logic [OUT_W-1:0]  result_c
);

    logic [OUT_W-1:0] acc_q;
    logic [OUT_W-1:0] acc_d;
    logic [OUT_W-1:0] ext_c;

    // result_c is the value this lane would hold after the current plane.
    always_comb begin
        ext_c    = OUT_W'($signed(psum_in));
        result_c = load ? ext_c : OUT_W'((acc_q << 1) + ext_c);
        acc_d    = acc_q;
        if (load || accum) begin
            acc_d = result_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/psum_shift_add.sv
// Combines MSB-first activation bit-planes of 64 signed partial sums into
// full-precision dot-product results, emitted as one registered word per group.
module psum_shift_add
    import cim_pkg::*;
#(
    parameter int unsigned PSUM_PRECISION = DEFAULT_PSUM_PRECISION,
    parameter int unsigned OUT_PRECISION  = DEFAULT_OUT_PRECISION,
    parameter int unsigned ACT_BITS       = DEFAULT_ACT_BITS
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              psum_valid,
    input  logic                              psum_first,
    input  logic [PSUM_PRECISION*LANES-1:0]   psum_in,
    output logic [OUT_PRECISION*LANES-1:0]    acc_out,
    output logic                              acc_valid,
    output logic                              seq_err
);

    localparam int unsigned CNT_W = cnt_width(ACT_BITS);

    psum_state_e                       state_q, state_d;
    logic [CNT_W-1:0]                  bit_cnt_q, bit_cnt_d;
    logic [OUT_PRECISION*LANES-1:0]    acc_out_q, acc_out_d;
    logic                              acc_valid_q, acc_valid_d;
    logic                              seq_err_q, seq_err_d;
    logic                              load_c;
    logic                              accum_c;
    logic                              done_c;
    logic [OUT_PRECISION*LANES-1:0]    result_c;

    for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
        psum_lane_shift_add #(
            .PSUM_W (PSUM_PRECISION),
            .OUT_W  (OUT_PRECISION)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load_c),
            .accum    (accum_c),
            .psum_in  (psum_in[PSUM_PRECISION*i +: PSUM_PRECISION]),
            .result_c (result_c[OUT_PRECISION*i +: OUT_PRECISION])
        );
    end

    // A first-flagged plane always starts a group; in ACCUM it also flags the
    // abandoned partial group.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        load_c      = 1'b0;
        accum_c     = 1'b0;
        done_c      = 1'b0;
        seq_err_d   = 1'b0;

        if (psum_valid) begin
            if (psum_first) begin
                seq_err_d = (state_q == ACCUM);
                load_c    = 1'b1;
                if (ACT_BITS == 1) begin
                    done_c    = 1'b1;
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else begin
                    state_d   = ACCUM;
                    bit_cnt_d = CNT_W'(1);
                end
            end else if (state_q == IDLE) begin
                seq_err_d = 1'b1;
            end else begin
                accum_c = 1'b1;
                if (bit_cnt_q == CNT_W'(ACT_BITS - 1)) begin
                    done_c    = 1'b1;
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
        end

        acc_valid_d = done_c;
        acc_out_d   = done_c ? result_c : acc_out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            acc_out_q   <= '0;
            acc_valid_q <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            acc_out_q   <= acc_out_d;
            acc_valid_q <= acc_valid_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign acc_out   = acc_out_q;
    assign acc_valid = acc_valid_q;
    assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_psum_shift_add.sv
// Scoreboard bench for psum_shift_add: default 4-plane build plus an ACT_BITS=1 build.
module tb_psum_shift_add;
    import cim_pkg::*;

    localparam int unsigned PW = 14;
    localparam int unsigned OW = 18;
    localparam int unsigned NL = 64;

    typedef logic [NL*PW-1:0] psum_t;
    typedef logic [NL*OW-1:0] out_t;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  psum_valid, psum_first;
    psum_t psum_in;
    out_t  acc_out;
    logic  acc_valid, seq_err;
    logic  psum_valid1, psum_first1;
    psum_t psum_in1;
    out_t  acc_out1;
    logic  acc_valid1, seq_err1;

    int   total = 0;
    int   bad   = 0;
    out_t exp_q[$];
    out_t last_exp;
    int   plane_v [4][64];

    always #5 clk = ~clk;

    psum_shift_add #(.PSUM_PRECISION(PW), .OUT_PRECISION(OW), .ACT_BITS(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .psum_valid(psum_valid), .psum_first(psum_first),
        .psum_in(psum_in), .acc_out(acc_out), .acc_valid(acc_valid), .seq_err(seq_err)
    );

    psum_shift_add #(.PSUM_PRECISION(PW), .OUT_PRECISION(OW), .ACT_BITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .psum_valid(psum_valid1), .psum_first(psum_first1),
        .psum_in(psum_in1), .acc_out(acc_out1), .acc_valid(acc_valid1), .seq_err(seq_err1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic psum_t pack_plane(input int k);
        psum_t p;
        for (int i = 0; i < int'(NL); i++) p[i*PW +: PW] = PW'(plane_v[k][i]);
        return p;
    endfunction

    // Reference: MSB-first weighting of the four planes, wrapped to OW bits.
    function automatic out_t model_group();
        out_t o;
        for (int i = 0; i < int'(NL); i++) begin
            int s = 0;
            for (int k = 0; k < 4; k++) s = s * 2 + plane_v[k][i];
            o[i*OW +: OW] = OW'(s);
        end
        return o;
    endfunction

    task automatic check_lanes(input string tag, input out_t got, input out_t exp);
        for (int i = 0; i < int'(NL); i++)
            chk($sformatf("%s[%0d]", tag, i), 32'(got[i*OW +: OW]), 32'(exp[i*OW +: OW]));
    endtask

    task automatic set_planes(input int a, input int b, input int c, input int d, input bit all);
        for (int i = 0; i < int'(NL); i++) begin
            plane_v[0][i] = (all || i == 0) ? a : 0;
            plane_v[1][i] = (all || i == 0) ? b : 0;
            plane_v[2][i] = (all || i == 0) ? c : 0;
            plane_v[3][i] = (all || i == 0) ? d : 0;
        end
    endtask

    task automatic set_random();
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < int'(NL); i++)
                plane_v[k][i] = int'($urandom_range(16383)) - 8192;
    endtask

    task automatic observe(input logic exp_err, input logic exp_done);
        out_t e;
        chk("seq_err", 32'(seq_err), 32'(exp_err));
        chk("acc_valid", 32'(acc_valid), 32'(exp_done));
        if (acc_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_lanes("res", acc_out, e);
                last_exp = e;
            end
        end else begin
            chk("hold", 32'(acc_out == last_exp), 32'd1);
        end
    endtask

    task automatic send_plane(input int k, input logic first, input logic exp_err, input logic exp_done);
        if (exp_done) exp_q.push_back(model_group());
        psum_valid = 1'b1;
        psum_first = first;
        psum_in    = pack_plane(k);
        @(posedge clk);
        #1;
        psum_valid = 1'b0;
        psum_first = 1'b0;
        observe(exp_err, exp_done);
    endtask

    task automatic send_group();
        send_plane(0, 1'b1, 1'b0, 1'b0);
        send_plane(1, 1'b0, 1'b0, 1'b0);
        send_plane(2, 1'b0, 1'b0, 1'b0);
        send_plane(3, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            psum_valid = 1'b0;
            @(posedge clk);
            #1;
            observe(1'b0, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        out_t e1;
        int   v;
        rst_n       = 1'b0;
        psum_valid  = 1'b0;
        psum_first  = 1'b0;
        psum_in     = '0;
        psum_valid1 = 1'b0;
        psum_first1 = 1'b0;
        psum_in1    = '0;
        last_exp    = '0;
        repeat (2) @(posedge clk);
        #1;
        check_lanes("rst_out", acc_out, '0);
        chk("rst_valid", 32'(acc_valid), 32'd0);
        chk("rst_err", 32'(seq_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Lane 0 planes 3,-1,2,5 -> 29; single pulse
        set_planes(3, -1, 2, 5, 1'b0);
        send_group();
        idle(1);

        // Extremes, back to back
        set_planes(-8192, -8192, -8192, -8192, 1'b1);
        send_group();
        set_planes(8191, 8191, 8191, 8191, 1'b1);
        send_group();

        // Back-to-back random groups, 3-cycle gap inside the second
        set_random();
        send_group();
        set_random();
        send_plane(0, 1'b1, 1'b0, 1'b0);
        send_plane(1, 1'b0, 1'b0, 1'b0);
        idle(3);
        send_plane(2, 1'b0, 1'b0, 1'b0);
        send_plane(3, 1'b0, 1'b0, 1'b1);

        // Non-first plane in IDLE is dropped
        set_random();
        send_plane(1, 1'b0, 1'b1, 1'b0);
        idle(1);

        // Premature restart on plane 2
        send_plane(0, 1'b1, 1'b0, 1'b0);
        send_plane(1, 1'b0, 1'b0, 1'b0);
        set_random();
        send_plane(0, 1'b1, 1'b1, 1'b0);
        send_plane(1, 1'b0, 1'b0, 1'b0);
        send_plane(2, 1'b0, 1'b0, 1'b0);
        send_plane(3, 1'b0, 1'b0, 1'b1);

        // Async reset mid-group
        set_random();
        send_plane(0, 1'b1, 1'b0, 1'b0);
        send_plane(1, 1'b0, 1'b0, 1'b0);
        send_plane(2, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_lanes("arst_out", acc_out, '0);
        chk("arst_valid", 32'(acc_valid), 32'd0);
        chk("arst_err", 32'(seq_err), 32'd0);
        last_exp = '0;
        @(negedge clk);
        rst_n = 1'b1;
        set_random();
        send_group();
        idle(2);

        // ACT_BITS = 1 build: every first plane completes
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < int'(NL); i++) begin
                v = (c == 0) ? -5 : int'($urandom_range(16383)) - 8192;
                psum_in1[i*PW +: PW] = PW'(v);
                e1[i*OW +: OW]       = OW'(v);
            end
            psum_valid1 = 1'b1;
            psum_first1 = 1'b1;
            @(posedge clk);
            #1;
            chk("ab1_valid", 32'(acc_valid1), 32'd1);
            chk("ab1_err", 32'(seq_err1), 32'd0);
            check_lanes("ab1_res", acc_out1, e1);
        end
        psum_valid1 = 1'b0;
        psum_first1 = 1'b0;
        @(posedge clk);
        #1;
        chk("ab1_idle_valid", 32'(acc_valid1), 32'd0);
        chk("ab1_hold", 32'(acc_out1 == e1), 32'd1);
        psum_valid1 = 1'b1;
        @(posedge clk);
        #1;
        psum_valid1 = 1'b0;
        chk("ab1_nf_err", 32'(seq_err1), 32'd1);
        chk("ab1_nf_valid", 32'(acc_valid1), 32'd0);

        chk("sb_left", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psum_shift_add.md
# psum_shift_add

Bit-serial shift-and-add accumulator for the CIM datapath. The CIM macro evaluates one activation bit-plane per cycle, MSB first, for unsigned ACT_BITS-bit activations. For each plane it delivers 64 signed partial sums. This block combines the planes into 64 full-precision signed dot-product results and emits them as one registered word. That word is the 64×OUT_PRECISION bus consumed by the ReLU/quantize stage, which feeds the next layer's activations.

## Interface

- PSUM_PRECISION, 14, width of each signed per-plane partial sum from the macro
- OUT_PRECISION, 18, width of each signed accumulated lane result (matches the ReLU input precision)
- ACT_BITS, 4, number of activation bit-planes per group (matches the ReLU output precision)
- clk  input  1  clock; all state updates on posedge
- rst_n  input  1  reset, asynchronous, active-low
- psum_valid  input  1  psum_in carries a bit-plane this cycle
- psum_first  input  1  qualifies psum_valid; this plane is the MSB plane (starts a group)
- psum_in  input  PSUM_PRECISION*64  lane i at bits [PSUM_PRECISION*(i+1)-1 -: PSUM_PRECISION], two's complement
- acc_out  output  OUT_PRECISION*64  completed lane results, same lane packing with OUT_PRECISION, registered
- acc_valid  output  1  one-cycle pulse: acc_out updated this cycle
- seq_err  output  1  one-cycle pulse: protocol violation detected (see Operation)

## Operation

- States: IDLE, ACCUM. Plane counter bit_cnt is clog2(ACT_BITS) bits wide. Internal accumulator acc is 64×OUT_PRECISION and separate from acc_out.
- Lane arithmetic: ext(p) is p sign-extended to OUT_PRECISION bits. The update is acc_next = (acc << 1) + ext(p), modulo 2^OUT_PRECISION; there is no saturation.
  - With the default widths the true range is bounded by ±(2^13)·(2^4−1), so no overflow occurs.
- IDLE:
  - psum_valid & psum_first: acc ← ext(psum_in), bit_cnt ← 1, then go to ACCUM.
  - psum_valid & !psum_first: the plane is dropped and seq_err pulses. State stays IDLE.
- ACCUM:
  - psum_valid & !psum_first: acc ← acc_next, bit_cnt ← bit_cnt+1.
  - When the accepted plane is the last one (bit_cnt == ACT_BITS−1), the completed value is written to acc_out, acc_valid pulses, and the state returns to IDLE.
- ACCUM with psum_valid & psum_first (a premature restart):
  - The partial group is discarded and seq_err pulses.
  - The new plane starts a new group exactly as from IDLE.
- psum_valid low: acc, bit_cnt and state hold. Gaps are allowed anywhere inside a group.
- ACT_BITS == 1: the first plane is also the last. acc_out ← ext(psum_in) and acc_valid pulses. There is no ACCUM dwell.
- acc_out holds its last completed value until the next completion, so the next group's accumulation does not disturb it.
- Reset values: state IDLE, bit_cnt 0, acc 0, acc_out 0, acc_valid 0, seq_err 0.

## Timing

- Latency: acc_out and acc_valid change on the clock edge that accepts the last plane, so they are visible in the cycle after that plane is presented.
- Group throughput: one group per ACT_BITS accepted cycles. The first plane of the next group may arrive in the cycle immediately after the previous group's last plane; no bubble is required.
- acc_valid and seq_err are each high for exactly one cycle per event. Both are registered.
- Reset asserted mid-group: everything clears immediately, asynchronously. No acc_valid is produced for the interrupted group. The first plane after rst_n deasserts must carry psum_first.
- The macro's timing is the producer's responsibility: there is no ready/backpressure, and every valid plane is consumed in the cycle it is presented.

## Structure

- Shared package cim_pkg holds:
  - LANES = 64
  - default PSUM_PRECISION, OUT_PRECISION and ACT_BITS constants, shared with the ReLU stage
  - the state enum {IDLE, ACCUM}
- Sub-module psum_lane_shift_add: one lane's sign-extend, shift-add and acc register, with load/accumulate controls. It is instantiated 64× in a generate loop.
- The top level owns the FSM, bit_cnt, acc_out/acc_valid registers and seq_err.

## Test plan

- Single group, lane 0 planes 3, −1, 2, 5 (MSB first, first on plane 0), other lanes 0 → one cycle after the 4th plane, lane 0 of acc_out = 29, other lanes 0, acc_valid pulses once.
- All lanes −8192 on all 4 planes → every lane = −122880 (18-bit 0x22000), with no wrap. Then all lanes 8191 → 122865.
- Back-to-back groups with no gap, and a 3-cycle psum_valid gap inside group 2 → two acc_valid pulses. Group 1's result holds on acc_out throughout group 2 until group 2 completes.
- psum_first asserted on plane 2 of a group → seq_err pulses once, the old group produces no output, and the new group completes after 4 planes with the correct value. A non-first plane sent in IDLE → seq_err pulses and it is ignored.
- rst_n pulled low after plane 2 → all outputs 0 at once. After release, a full group produces the correct result with no leftover from the aborted group.
- ACT_BITS = 1 build: plane of −5 with psum_first → acc_out lane = −5 and acc_valid the next cycle, one per valid cycle.
